// File: rtl/game_retract_ctrl_pkg.sv
// Shared game definitions: history-bank source select encoding, controller FSM state type and
// history depth.
package game_retract_ctrl_pkg;

   localparam int unsigned HIST_DEPTH = 3;

   typedef logic [1:0] sel_t;

   // Also decoded by the history bank's input mux.
   localparam sel_t SEL_INIT    = 2'd0;
   localparam sel_t SEL_BM      = 2'd1;
   localparam sel_t SEL_MM      = 2'd2;
   localparam sel_t SEL_RETRACT = 2'd3;

   typedef enum logic [2:0] {
      StBoot,
      StIdle,
      StInit,
      StCommit,
      StPop,
      StAck,
      StRelease
   } state_t;

   function automatic sel_t move_sel(input logic box);
      return box ? SEL_BM : SEL_MM;
   endfunction

endpackage

// File: rtl/game_retract_ctrl_if.sv
// Request/response bundle between the move-decision logic (master) and the retract controller
// (slave).
interface game_retract_ctrl_if
   import game_retract_ctrl_pkg::*;
#(
   parameter int unsigned STEP_W = 10
);
   logic              init_req;
   logic              move_req;
   logic              move_box;
   logic              retract_req;
   logic              lock;
   sel_t              sel;
   logic              state_en;
   logic              ack;
   logic              denied;
   logic [1:0]        undo_avail;
   logic [STEP_W-1:0] steps;
   logic              busy;

   modport master (
      output init_req, move_req, move_box, retract_req, lock,
      input  sel, state_en, ack, denied, undo_avail, steps, busy
   );

   modport slave (
      input  init_req, move_req, move_box, retract_req, lock,
      output sel, state_en, ack, denied, undo_avail, steps, busy
   );

endinterface

// File: rtl/game_sat_counter.sv
// Up/down counter with synchronous clear; saturates at MAX going up and at 0 going down.
module game_sat_counter #(
   parameter int unsigned W   = 2,
   parameter int unsigned MAX = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] MaxVal = W'(MAX);

   logic [W-1:0] count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (inc) begin
         if (count_q != MaxVal) count_q <= count_q + W'(1);
      end else if (dec) begin
         if (count_q != '0) count_q <= count_q - W'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/game_retract_ctrl.sv
// Undo-history sequencer: arbitrates init/move/retract requests and issues one bank write per
// accepted request, tracking available undo steps and the player step count.
module game_retract_ctrl
   import game_retract_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH    = HIST_DEPTH,
   parameter int unsigned STEP_W   = 10,
   parameter int unsigned STEP_MAX = 999
) (
   input logic                clk,
   input logic                rst,
   game_retract_ctrl_if.slave bus
);

   state_t     state_q;
   sel_t       sel_q;
   logic       state_en_q;
   logic       ack_q;
   logic       denied_q;
   logic       busy_q;
   logic [1:0] undo_cnt;
   logic [STEP_W-1:0] step_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StBoot;
         sel_q      <= SEL_INIT;
         state_en_q <= 1'b0;
         ack_q      <= 1'b0;
         denied_q   <= 1'b0;
         busy_q     <= 1'b1;
      end else begin
         state_en_q <= 1'b0;
         ack_q      <= 1'b0;
         denied_q   <= 1'b0;
         busy_q     <= 1'b1;
         unique case (state_q)
            StBoot: begin
               state_q    <= StInit;
               sel_q      <= SEL_INIT;
               state_en_q <= 1'b1;
            end
            StIdle: begin
               if (bus.init_req) begin
                  state_q    <= StInit;
                  sel_q      <= SEL_INIT;
                  state_en_q <= 1'b1;
               end else if (bus.retract_req) begin
                  if (!bus.lock && undo_cnt != 2'd0) begin
                     state_q    <= StPop;
                     sel_q      <= SEL_RETRACT;
                     state_en_q <= 1'b1;
                  end else begin
                     state_q  <= StRelease;
                     denied_q <= 1'b1;
                  end
               end else if (bus.move_req && !bus.lock) begin
                  // sel captures move_box here, so later changes to it are ignored.
                  state_q    <= StCommit;
                  sel_q      <= move_sel(bus.move_box);
                  state_en_q <= 1'b1;
               end else begin
                  busy_q <= 1'b0;
               end
            end
            StInit, StCommit, StPop: begin
               state_q <= StAck;
               ack_q   <= 1'b1;
            end
            StAck: begin
               state_q <= StRelease;
            end
            StRelease: begin
               if (!bus.init_req && !bus.move_req && !bus.retract_req) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= StBoot;
            end
         endcase
      end
   end

   // Counters advance on the edge that ends the write cycle, alongside the bank capture.
   game_sat_counter #(
      .W   (2),
      .MAX (DEPTH)
   ) u_undo_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (state_q == StInit),
      .inc   (state_q == StCommit),
      .dec   (state_q == StPop),
      .count (undo_cnt)
   );

   game_sat_counter #(
      .W   (STEP_W),
      .MAX (STEP_MAX)
   ) u_step_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (state_q == StInit),
      .inc   (state_q == StCommit),
      .dec   (state_q == StPop),
      .count (step_cnt)
   );

   assign bus.sel        = sel_q;
   assign bus.state_en   = state_en_q;
   assign bus.ack        = ack_q;
   assign bus.denied     = denied_q;
   assign bus.busy       = busy_q;
   assign bus.undo_avail = undo_cnt;
   assign bus.steps      = step_cnt;

endmodule

// File: tb/tb_game_retract_ctrl.sv
// Directed bench for game_retract_ctrl: a per-cycle vector table from reset release, plus a
// hand-written asynchronous-reset-during-commit sequence.
module tb_game_retract_ctrl;

   localparam int unsigned STEP_W = 10;

   typedef struct {
      logic       init_req;
      logic       move_req;
      logic       move_box;
      logic       retract_req;
      logic       lock;
      logic [1:0] sel;
      logic       state_en;
      logic       ack;
      logic       denied;
      logic [1:0] undo;
      int         steps;
      logic       busy;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   vec_t tbl[$];

   game_retract_ctrl_if #(.STEP_W(STEP_W)) bus ();

   game_retract_ctrl #(
      .DEPTH    (3),
      .STEP_W   (STEP_W),
      .STEP_MAX (999)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(input logic i, input logic m, input logic b, input logic r,
                               input logic l, input logic [1:0] sel, input logic en,
                               input logic ack, input logic den, input logic [1:0] u,
                               input int s, input logic busy);
      vec_t v;
      v.init_req = i; v.move_req = m; v.move_box = b; v.retract_req = r; v.lock = l;
      v.sel = sel; v.state_en = en; v.ack = ack; v.denied = den; v.undo = u;
      v.steps = s; v.busy = busy;
      return v;
   endfunction

   function automatic logic [17:0] pack(input logic [1:0] sel, input logic en, input logic ack,
                                        input logic den, input logic [1:0] u,
                                        input logic [STEP_W-1:0] s, input logic busy);
      return {sel, en, ack, den, u, s, busy};
   endfunction

   function automatic logic [17:0] observed();
      return pack(bus.sel, bus.state_en, bus.ack, bus.denied, bus.undo_avail, bus.steps,
                  bus.busy);
   endfunction

   task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got sel=%0d en=%0b ack=%0b den=%0b undo=%0d steps=%0d busy=%0b, want sel=%0d en=%0b ack=%0b den=%0b undo=%0d steps=%0d busy=%0b",
                  name, act[17:16], act[15], act[14], act[13], act[12:11], act[10:1], act[0],
                  exp[17:16], exp[15], exp[14], exp[13], exp[12:11], exp[10:1], exp[0]);
      end
   endtask

   task automatic drive(input logic i, input logic m, input logic b, input logic r,
                        input logic l);
      bus.init_req = i; bus.move_req = m; bus.move_box = b; bus.retract_req = r; bus.lock = l;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      drive(0, 0, 0, 0, 0);

      //             i  m  b  r  l   sel en ack den u  s  busy
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1)); // BOOT -> INIT
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1)); // held box move
      tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 1, 0, 1, 1, 1));
      tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 1, 1, 1));
      tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 1, 1, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 2, 1, 0, 0, 1, 1, 1)); // man move
      tbl.push_back(mk(0, 0, 0, 0, 0, 2, 0, 1, 0, 2, 2, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 2, 0, 0, 0, 2, 2, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 2, 0, 0, 0, 2, 2, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 0, 0, 2, 2, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 3, 3, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 3, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 3, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 2, 1, 0, 0, 3, 3, 1)); // 4th move: undo saturates
      tbl.push_back(mk(0, 0, 0, 0, 0, 2, 0, 1, 0, 3, 4, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 2, 0, 0, 0, 3, 4, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 2, 0, 0, 0, 3, 4, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 3, 1, 0, 0, 3, 4, 1)); // retract
      tbl.push_back(mk(0, 0, 0, 1, 0, 3, 0, 1, 0, 2, 3, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 3, 0, 0, 0, 2, 3, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 2, 3, 0));
      tbl.push_back(mk(0, 1, 0, 0, 1, 3, 0, 0, 0, 2, 3, 0)); // locked move ignored
      tbl.push_back(mk(0, 0, 0, 1, 1, 3, 0, 0, 1, 2, 3, 1)); // locked retract denied
      tbl.push_back(mk(0, 0, 0, 1, 1, 3, 0, 0, 0, 2, 3, 1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 0, 2, 3, 0));
      tbl.push_back(mk(1, 1, 0, 1, 1, 0, 1, 0, 0, 2, 3, 1)); // all three + lock: INIT wins
      tbl.push_back(mk(1, 1, 0, 1, 1, 0, 0, 1, 0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1)); // retract with no undo
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 2, 1, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 2, 0, 1, 0, 1, 1, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 1, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 1, 0));

      tick();
      check("reset_values", observed(), pack(2'd0, 0, 0, 0, 2'd0, '0, 1));
      rst = 1'b0;

      foreach (tbl[k]) begin
         drive(tbl[k].init_req, tbl[k].move_req, tbl[k].move_box, tbl[k].retract_req,
               tbl[k].lock);
         tick();
         check($sformatf("vec%0d", k), observed(),
               pack(tbl[k].sel, tbl[k].state_en, tbl[k].ack, tbl[k].denied, tbl[k].undo,
                    STEP_W'(tbl[k].steps), tbl[k].busy));
      end

      // Asynchronous reset landing in the COMMIT write cycle.
      drive(0, 1, 1, 0, 0);
      tick();
      check("commit_before_rst", observed(), pack(2'd1, 1, 0, 0, 2'd1, STEP_W'(1), 1));
      drive(0, 0, 0, 0, 0);
      #2 rst = 1'b1;
      #1 check("rst_async_clear", observed(), pack(2'd0, 0, 0, 0, 2'd0, '0, 1));
      tick();
      check("rst_held", observed(), pack(2'd0, 0, 0, 0, 2'd0, '0, 1));
      rst = 1'b0;
      tick();
      check("reload_init", observed(), pack(2'd0, 1, 0, 0, 2'd0, '0, 1));
      tick();
      check("reload_ack", observed(), pack(2'd0, 0, 1, 0, 2'd0, '0, 1));
      tick();
      check("reload_release", observed(), pack(2'd0, 0, 0, 0, 2'd0, '0, 1));
      tick();
      check("reload_idle", observed(), pack(2'd0, 0, 0, 0, 2'd0, '0, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
